// File: rtl/mem_stage_hs.sv
// Memory/writeback stage with valid/ready handshake and a req/ack memory port guarded by a timeout.
// Optional MEMSTAGE_ALIGN_CHECK_EN: odd-address memory ops are rejected without issuing a request.
package mem_stage_hs_pkg;
    typedef struct packed {
        logic mem2r;
        logic memwr;
    } memc_t;
endpackage

module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int ALU_W   = 32,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] instruction_i,
    input  logic [ALU_W-1:0]   alu_i,
    input  memc_t              memc_i,
    input  logic [DATA_W-1:0]  r1_data_i,
    input  logic               r0_en_i,
    input  logic               halt_sys_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [DATA_W-1:0]  mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [DATA_W-1:0]  mem_rdata_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ALU_W-1:0]   data_o,
    output logic [DATA_W-1:0]  r1_data_out_o,
    output memc_t              out_memc_o,
    output logic               out_r0_en_o,
    output logic [INSTR_W-1:0] instruction_out_o,
    output logic               mem_timeout_o,
    output logic               misalign_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ALU_W-1:0]   alu_q, alu_d;
    logic [DATA_W-1:0]  low_q, low_d;
    logic [DATA_W-1:0]  r1_q, r1_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    memc_t              memc_q, memc_d;
    logic               r0en_q, r0en_d;
    logic               timeout_q, timeout_d;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    logic               misalign_q, misalign_d;
`endif
    logic               accept;
    logic               memOp;

    assign in_ready_o = !halt_sys_i && ((state_q == IDLE) || ((state_q == OUT) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;
    assign memOp      = memc_i.memwr | memc_i.mem2r;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_d     = alu_q;
        low_d     = low_q;
        r1_d      = r1_q;
        instr_d   = instr_q;
        memc_d    = memc_q;
        r0en_d    = r0en_q;
        timeout_d = 1'b0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            REQ: begin
                // A write wins when both flags are set, so only a pure load takes read data.
                if (mem_ack_i) begin
                    low_d   = (memc_q.mem2r && !memc_q.memwr) ? mem_rdata_i : alu_q[DATA_W-1:0];
                    cnt_d   = '0;
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    low_d     = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: ;
        endcase

        // Accepts only happen in IDLE or a draining OUT, so they override the case above.
        if (accept) begin
            instr_d = instruction_i;
            alu_d   = alu_i;
            memc_d  = memc_i;
            r1_d    = r1_data_i;
            r0en_d  = r0_en_i;
            cnt_d   = '0;
            if (memOp) begin
                low_d = '0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
                if (alu_i[0]) begin
                    state_d    = OUT;
                    misalign_d = 1'b1;
                end else begin
                    state_d = REQ;
                end
`else
                state_d = REQ;
`endif
            end else begin
                low_d   = alu_i[DATA_W-1:0];
                state_d = OUT;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_q     <= '0;
            low_q     <= '0;
            r1_q      <= '0;
            instr_q   <= '0;
            memc_q    <= '0;
            r0en_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_q     <= alu_d;
            low_q     <= low_d;
            r1_q      <= r1_d;
            instr_q   <= instr_d;
            memc_q    <= memc_d;
            r0en_q    <= r0en_d;
            timeout_q <= timeout_d;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign mem_req_o         = (state_q == REQ);
    assign mem_we_o          = memc_q.memwr;
    assign mem_addr_o        = alu_q[ADDR_W-1:0];
    assign mem_wdata_o       = r1_q;
    assign out_valid_o       = (state_q == OUT);
    assign data_o            = {alu_q[ALU_W-1:DATA_W], low_q};
    assign r1_data_out_o     = r1_q;
    assign out_memc_o        = memc_q;
    assign out_r0_en_o       = r0en_q;
    assign instruction_out_o = instr_q;
    assign mem_timeout_o     = timeout_q;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    assign misalign_o        = misalign_q;
`else
    assign misalign_o        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Testbench for mem_stage_hs: directed scenarios plus randomized ops against a per-transaction reference model.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    localparam int TMO = 4;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    localparam memc_t ALUOP = '{mem2r: 1'b0, memwr: 1'b0};
    localparam memc_t LD    = '{mem2r: 1'b1, memwr: 1'b0};
    localparam memc_t ST    = '{mem2r: 1'b0, memwr: 1'b1};
    localparam memc_t BOTH  = '{mem2r: 1'b1, memwr: 1'b1};

    typedef struct packed {
        logic [15:0] instr;
        logic [31:0] alu;
        memc_t       memc;
        logic [15:0] r1;
        logic        r0en;
        logic [15:0] rdata;
    } op_t;

    typedef struct {
        int          reqCycles;
        int          latency;
        int          timeoutCount;
        int          misalignCount;
        logic        gotOut;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [31:0] data;
        logic [34:0] side;
        logic        stable;
        logic        idleAfter;
    } obs_t;

    typedef struct {
        int          reqCycles;
        int          latency;
        int          timeoutCount;
        int          misalignCount;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid, inReady;
    logic [15:0] instruction;
    logic [31:0] alu;
    memc_t       memc;
    logic [15:0] r1Data;
    logic        r0En, haltSys;
    logic        memReq, memWe;
    logic [15:0] memAddr, memWdata;
    logic        memAck;
    logic [15:0] memRdata;
    logic        outValid, outReady;
    logic [31:0] data;
    logic [15:0] r1DataOut;
    memc_t       outMemc;
    logic        outR0En;
    logic [15:0] instrOut;
    logic        memTimeout, misalign;

    int testsRun;
    int testsFailed;

    always #5 clk = ~clk;

    mem_stage_hs #(
        .ALU_W(32), .DATA_W(16), .ADDR_W(16), .INSTR_W(16), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rstN),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .instruction_i(instruction), .alu_i(alu), .memc_i(memc),
        .r1_data_i(r1Data), .r0_en_i(r0En), .halt_sys_i(haltSys),
        .mem_req_o(memReq), .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_ack_i(memAck), .mem_rdata_i(memRdata),
        .out_valid_o(outValid), .out_ready_i(outReady), .data_o(data),
        .r1_data_out_o(r1DataOut), .out_memc_o(outMemc), .out_r0_en_o(outR0En),
        .instruction_out_o(instrOut), .mem_timeout_o(memTimeout), .misalign_o(misalign)
    );

    // Reference model: what one transaction should look like, from the handshake rules alone.
    function automatic exp_t model_op(input op_t op, input int lat);
        exp_t ex;
        logic isMem, bad;
        isMem            = op.memc.memwr | op.memc.mem2r;
        bad              = ALIGN && isMem && op.alu[0];
        ex.timeoutCount  = 0;
        ex.misalignCount = bad ? 1 : 0;
        if (!isMem || bad) begin
            ex.reqCycles = 0;
            ex.latency   = 1;
            ex.data      = {op.alu[31:16], bad ? 16'h0000 : op.alu[15:0]};
        end else if (lat > TMO) begin
            ex.reqCycles    = TMO;
            ex.latency      = TMO + 1;
            ex.timeoutCount = 1;
            ex.data         = {op.alu[31:16], 16'h0000};
        end else begin
            ex.reqCycles = lat;
            ex.latency   = lat + 1;
            ex.data      = {op.alu[31:16], (op.memc.mem2r && !op.memc.memwr) ? op.rdata : op.alu[15:0]};
        end
        return ex;
    endfunction

    function automatic op_t make_op(input logic [15:0] ins, input logic [31:0] a, input memc_t mc,
                                    input logic [15:0] r1, input logic r0, input logic [15:0] rd);
        op_t op;
        op.instr = ins; op.alu = a; op.memc = mc; op.r1 = r1; op.r0en = r0; op.rdata = rd;
        return op;
    endfunction

    // Drives one op, acks on the lat-th request cycle, stalls the output for hold cycles, and records what it saw.
    task automatic do_op(input op_t op, input int lat, input int hold, output obs_t ob);
        ob.reqCycles = 0; ob.latency = 0; ob.timeoutCount = 0; ob.misalignCount = 0;
        ob.gotOut = 1'b0; ob.we = 1'b0; ob.addr = '0; ob.wdata = '0; ob.data = '0; ob.side = '0;
        ob.stable = 1'b1; ob.idleAfter = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b1; instruction = op.instr; alu = op.alu; memc = op.memc;
        r1Data = op.r1; r0En = op.r0en; outReady = 1'b0; memAck = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0; instruction = 16'($urandom); alu = $urandom; memc = ALUOP;
        r1Data = 16'($urandom); r0En = ~op.r0en;
        for (int cyc = 1; cyc <= 40 && !ob.gotOut; cyc++) begin
            @(negedge clk);
            if (memTimeout) ob.timeoutCount++;
            if (misalign) ob.misalignCount++;
            if (memReq) begin
                ob.reqCycles++;
                ob.we = memWe; ob.addr = memAddr; ob.wdata = memWdata;
                if (ob.reqCycles == lat) begin
                    memAck = 1'b1; memRdata = op.rdata;
                end
            end
            if (outValid) begin
                ob.gotOut = 1'b1; ob.latency = cyc; ob.data = data;
                ob.side = {instrOut, r1DataOut, outMemc, outR0En};
            end else begin
                @(posedge clk); #1;
                memAck = 1'b0; memRdata = 16'($urandom);
            end
        end
        if (!ob.gotOut) return;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            memAck = 1'($urandom_range(0, 1)); memRdata = 16'($urandom);
            @(negedge clk);
            if (memTimeout) ob.timeoutCount++;
            if (misalign) ob.misalignCount++;
            if (!outValid || data !== ob.data || inReady !== 1'b0 || memReq) ob.stable = 1'b0;
        end
        @(posedge clk); #1;
        outReady = 1'b1; memAck = 1'b0;
        @(posedge clk); #1;
        outReady = 1'b0;
        @(negedge clk);
        if (memTimeout) ob.timeoutCount++;
        if (misalign) ob.misalignCount++;
        ob.idleAfter = !outValid && inReady && !memReq;
    endtask

    task automatic test_reset();
        rstN = 1'b0; inValid = 1'b1; alu = 32'hFFFF_FFFF; memc = LD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if ({outValid, memReq, memTimeout, misalign, data, r1DataOut, outMemc, outR0En, instrOut} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got data=%h req=%b valid=%b, expected all zero", data, memReq, outValid);
        end
        testsRun++;
        if (inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_in_ready: got %b, expected 1", inReady);
        end
        inValid = 1'b0; memc = ALUOP;
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_alu_op();
        obs_t ob;
        do_op(make_op(16'hA001, 32'h1234_5678, ALUOP, 16'h7777, 1'b1, 16'hDEAD), 1, 0, ob);
        testsRun++;
        if (ob.data !== 32'h1234_5678 || ob.latency !== 1 || ob.reqCycles !== 0) begin
            testsFailed++;
            $display("[TB] FAIL alu_op: got data=%h lat=%0d req=%0d, expected 12345678/1/0", ob.data, ob.latency, ob.reqCycles);
        end
        testsRun++;
        if (ob.side !== {16'hA001, 16'h7777, ALUOP, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL alu_sideband: got %h, expected %h", ob.side, {16'hA001, 16'h7777, ALUOP, 1'b1});
        end
    endtask

    task automatic test_load();
        obs_t ob;
        do_op(make_op(16'hB002, 32'h00AB_0010, LD, 16'h0000, 1'b0, 16'hBEEF), 3, 0, ob);
        testsRun++;
        if (ob.reqCycles !== 3 || ob.we !== 1'b0 || ob.addr !== 16'h0010) begin
            testsFailed++;
            $display("[TB] FAIL load_req: got cycles=%0d we=%b addr=%h, expected 3/0/0010", ob.reqCycles, ob.we, ob.addr);
        end
        testsRun++;
        if (ob.data !== 32'h00AB_BEEF || ob.latency !== 4) begin
            testsFailed++;
            $display("[TB] FAIL load_data: got %h lat=%0d, expected 00abbeef lat=4", ob.data, ob.latency);
        end
    endtask

    task automatic test_store();
        obs_t ob;
        do_op(make_op(16'hC003, 32'h0000_0020, ST, 16'hCAFE, 1'b0, 16'h5555), 1, 0, ob);
        testsRun++;
        if (ob.reqCycles !== 1 || ob.we !== 1'b1 || ob.wdata !== 16'hCAFE || ob.addr !== 16'h0020) begin
            testsFailed++;
            $display("[TB] FAIL store_req: got cycles=%0d we=%b wdata=%h addr=%h, expected 1/1/cafe/0020",
                     ob.reqCycles, ob.we, ob.wdata, ob.addr);
        end
        testsRun++;
        if (ob.data[15:0] !== 16'h0020 || ob.latency !== 2) begin
            testsFailed++;
            $display("[TB] FAIL store_data: got %h lat=%0d, expected low 0020 lat=2", ob.data, ob.latency);
        end
    endtask

    task automatic test_both_flags();
        obs_t ob;
        do_op(make_op(16'hD004, 32'h0101_0030, BOTH, 16'h4242, 1'b1, 16'h9999), 2, 0, ob);
        testsRun++;
        if (ob.we !== 1'b1 || ob.data !== 32'h0101_0030) begin
            testsFailed++;
            $display("[TB] FAIL both_flags: got we=%b data=%h, expected 1/01010030", ob.we, ob.data);
        end
    endtask

    task automatic test_timeout();
        obs_t ob;
        do_op(make_op(16'hE005, 32'h0F0F_0040, LD, 16'h0000, 1'b0, 16'h1234), 99, 2, ob);
        testsRun++;
        if (ob.reqCycles !== TMO || ob.timeoutCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_req: got cycles=%0d pulses=%0d, expected %0d/1", ob.reqCycles, ob.timeoutCount, TMO);
        end
        testsRun++;
        if (ob.data !== 32'h0F0F_0000 || ob.latency !== TMO + 1) begin
            testsFailed++;
            $display("[TB] FAIL timeout_data: got %h lat=%0d, expected 0f0f0000 lat=%0d", ob.data, ob.latency, TMO + 1);
        end
    endtask

    task automatic test_stall();
        obs_t ob;
        do_op(make_op(16'hF006, 32'h0BAD_F00D, ALUOP, 16'h1111, 1'b1, 16'h2222), 1, 5, ob);
        testsRun++;
        if (ob.stable !== 1'b1 || ob.data !== 32'h0BAD_F00D) begin
            testsFailed++;
            $display("[TB] FAIL stall_hold: got stable=%b data=%h, expected 1/0badf00d", ob.stable, ob.data);
        end
        testsRun++;
        if (ob.idleAfter !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL stall_release: got idle=%b, expected 1", ob.idleAfter);
        end
    endtask

    task automatic test_halt();
        haltSys = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b1; alu = 32'h0000_3333; memc = ALUOP;
        @(negedge clk);
        testsRun++;
        if (inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_idle_ready: got %b, expected 0", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0 || memReq !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_blocks: got valid=%b req=%b, expected 0/0", outValid, memReq);
        end
        haltSys = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b1; alu = 32'h0055_0040; memc = LD;
        @(posedge clk); #1;
        inValid = 1'b0; haltSys = 1'b1;
        @(negedge clk);
        testsRun++;
        if (memReq !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL halt_req_kept: got %b, expected 1", memReq);
        end
        memAck = 1'b1; memRdata = 16'h1357;
        @(posedge clk); #1;
        memAck = 1'b0; outReady = 1'b1;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b1 || data !== 32'h0055_1357 || inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_complete: got valid=%b data=%h ready=%b, expected 1/00551357/0", outValid, data, inReady);
        end
        @(posedge clk); #1;
        outReady = 1'b0;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0 || inReady !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL halt_drain: got valid=%b ready=%b, expected 0/0", outValid, inReady);
        end
        haltSys = 1'b0;
    endtask

    task automatic test_ack_ignored();
        obs_t ob;
        @(posedge clk); #1;
        memAck = 1'b1; memRdata = 16'h1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun++;
        if (memReq !== 1'b0 || outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL ack_idle: got req=%b valid=%b, expected 0/0", memReq, outValid);
        end
        memAck = 1'b0;
        do_op(make_op(16'h0007, 32'h0000_2222, ALUOP, 16'h0000, 1'b0, 16'h1111), 1, 3, ob);
        testsRun++;
        if (ob.data !== 32'h0000_2222 || ob.stable !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL ack_out_ignored: got data=%h stable=%b, expected 00002222/1", ob.data, ob.stable);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [5];
        for (int i = 0; i < 5; i++) vals[i] = $urandom;
        @(posedge clk); #1;
        outReady = 1'b1; inValid = 1'b1; memc = ALUOP; alu = vals[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 4) alu = vals[k + 1];
            else inValid = 1'b0;
            @(negedge clk);
            testsRun++;
            if (outValid !== 1'b1 || data !== vals[k]) begin
                testsFailed++;
                $display("[TB] FAIL b2b_%0d: got valid=%b data=%h, expected 1/%h", k, outValid, data, vals[k]);
            end
        end
        @(posedge clk); #1;
        outReady = 1'b0;
        @(negedge clk);
        testsRun++;
        if (outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_drain: got valid=%b, expected 0", outValid);
        end
    endtask

    task automatic test_misalign();
        obs_t ob;
        do_op(make_op(16'h0008, 32'h0000_0011, LD, 16'h0000, 1'b0, 16'h7E57), 1, 0, ob);
`ifdef MEMSTAGE_ALIGN_CHECK_EN
        testsRun++;
        if (ob.reqCycles !== 0 || ob.misalignCount !== 1 || ob.latency !== 1 || ob.data !== 32'h0000_0000) begin
            testsFailed++;
            $display("[TB] FAIL misalign: got req=%0d pulses=%0d lat=%0d data=%h, expected 0/1/1/00000000",
                     ob.reqCycles, ob.misalignCount, ob.latency, ob.data);
        end
`else
        testsRun++;
        if (ob.reqCycles !== 1 || ob.addr !== 16'h0011 || ob.misalignCount !== 0 || ob.data !== 32'h0000_7E57) begin
            testsFailed++;
            $display("[TB] FAIL odd_addr_pass: got req=%0d addr=%h pulses=%0d data=%h, expected 1/0011/0/00007e57",
                     ob.reqCycles, ob.addr, ob.misalignCount, ob.data);
        end
`endif
    endtask

    task automatic test_reset_mid_req();
        @(posedge clk); #1;
        inValid = 1'b1; alu = 32'h0000_0044; memc = LD;
        @(posedge clk); #1;
        inValid = 1'b0; memc = ALUOP;
        @(negedge clk);
        testsRun++;
        if (memReq !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_req_before: got %b, expected 1", memReq);
        end
        #1 rstN = 1'b0;
        #1;
        testsRun++;
        if (memReq !== 1'b0 || outValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_req_async: got req=%b valid=%b, expected 0/0", memReq, outValid);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (memReq !== 1'b0 || outValid !== 1'b0 || inReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_no_retry: got req=%b valid=%b ready=%b, expected 0/0/1", memReq, outValid, inReady);
        end
    endtask

    task automatic test_random();
        memc_t kinds [4] = '{ALUOP, LD, ST, BOTH};
        op_t   op;
        obs_t  ob;
        exp_t  ex;
        int    lat, hold;
        for (int n = 0; n < 30; n++) begin
            op   = make_op(16'($urandom), $urandom, kinds[$urandom_range(0, 3)], 16'($urandom),
                           1'($urandom_range(0, 1)), 16'($urandom));
            lat  = $urandom_range(1, 6);
            hold = $urandom_range(0, 3);
            ex   = model_op(op, lat);
            do_op(op, lat, hold, ob);
            testsRun++;
            if (ob.gotOut !== 1'b1 || ob.data !== ex.data || ob.latency !== ex.latency) begin
                testsFailed++;
                $display("[TB] FAIL rand_%0d_data: got out=%b data=%h lat=%0d, expected 1/%h/%0d",
                         n, ob.gotOut, ob.data, ob.latency, ex.data, ex.latency);
            end
            testsRun++;
            if (ob.reqCycles !== ex.reqCycles || ob.timeoutCount !== ex.timeoutCount || ob.misalignCount !== ex.misalignCount) begin
                testsFailed++;
                $display("[TB] FAIL rand_%0d_req: got req=%0d tmo=%0d mis=%0d, expected %0d/%0d/%0d", n,
                         ob.reqCycles, ob.timeoutCount, ob.misalignCount, ex.reqCycles, ex.timeoutCount, ex.misalignCount);
            end
            testsRun++;
            if (ob.side !== {op.instr, op.r1, op.memc, op.r0en} || ob.stable !== 1'b1 || ob.idleAfter !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL rand_%0d_side: got side=%h stable=%b idle=%b, expected %h/1/1",
                         n, ob.side, ob.stable, ob.idleAfter, {op.instr, op.r1, op.memc, op.r0en});
            end
            if (ex.reqCycles > 0) begin
                testsRun++;
                if (ob.addr !== op.alu[15:0] || ob.we !== op.memc.memwr || ob.wdata !== op.r1) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_%0d_port: got addr=%h we=%b wdata=%h, expected %h/%b/%h",
                             n, ob.addr, ob.we, ob.wdata, op.alu[15:0], op.memc.memwr, op.r1);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun = 0; testsFailed = 0;
        rstN = 1'b0; inValid = 1'b0; instruction = '0; alu = '0; memc = ALUOP;
        r1Data = '0; r0En = 1'b0; haltSys = 1'b0; memAck = 1'b0; memRdata = '0; outReady = 1'b0;
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_both_flags();
        test_timeout();
        test_stall();
        test_halt();
        test_ack_ignored();
        test_back_to_back();
        test_misalign();
        test_reset_mid_req();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
